// File: rtl/l2r_exp_datapath.sv
// Datapath for the left-to-right square-and-multiply exponentiation unit.
// Computes result = base^exponent mod 2^WIDTH under CU control strobes.
module l2r_exp_datapath #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             ShiftB,
    input  logic             LoadCoun,
    input  logic             S_Coun,
    input  logic             LoadC,
    input  logic [1:0]       S_C,
    output logic             equals,
    output logic             prevRegB,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned PROD_W = 2 * WIDTH;

    logic [WIDTH-1:0]  regA;
    logic [WIDTH-1:0]  regB;
    logic [CNT_W-1:0]  counter;
    logic [WIDTH-1:0]  regC;

    logic [WIDTH-1:0]  regANext;
    logic [WIDTH-1:0]  regBNext;
    logic [CNT_W-1:0]  counterNext;
    logic [WIDTH-1:0]  regCNext;
    logic [PROD_W-1:0] squareProd;
    logic [PROD_W-1:0] mulProd;
    logic              counterFull;

    assign counterFull = (counter == CNT_W'(WIDTH));

    // Full-width products; only the low WIDTH bits are kept (mod 2^WIDTH).
    always_comb begin
        squareProd = PROD_W'(regC) * PROD_W'(regC);
        mulProd    = PROD_W'(regC) * PROD_W'(regA);
    end

    // Next-state selection for every register.
    always_comb begin
        regANext    = regA;
        regBNext    = regB;
        counterNext = counter;
        regCNext    = regC;

        if (LoadA) begin
            regANext = base;
        end

        if (LoadB) begin
            regBNext = exponent;
        end else if (ShiftB) begin
            regBNext = {regB[WIDTH-2:0], 1'b0};
        end

        if (LoadCoun) begin
            if (!S_Coun) begin
                counterNext = '0;
            end else if (!counterFull) begin
                counterNext = counter + CNT_W'(1);
            end
        end

        if (LoadC) begin
            unique case (S_C)
                2'b00:   regCNext = WIDTH'(1);
                2'b01:   regCNext = WIDTH'(squareProd);
                2'b10:   regCNext = WIDTH'(mulProd);
                default: regCNext = regC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regA    <= '0;
            regB    <= '0;
            counter <= '0;
            regC    <= '0;
        end else begin
            regA    <= regANext;
            regB    <= regBNext;
            counter <= counterNext;
            regC    <= regCNext;
        end
    end

    assign equals   = counterFull;
    assign prevRegB = regB[WIDTH-1];
    assign result   = regC;

endmodule

// File: doc/l2r_exp_datapath.md
Name: l2r_exp_datapath

Overview:
- Datapath for the left-to-right (square-and-multiply) exponentiation unit; computes C = A^B mod 2^WIDTH.
- Sits directly downstream of the CU.
  - Consumes the CU control strobes: LoadA, LoadB, ShiftB, LoadCoun, S_Coun, LoadC, S_C.
  - Returns the status flags the CU branches on: equals, prevRegB.
- Holds the operand registers, the exponent shift register, the bit counter and the accumulator/multiplier.

Parameters:
- WIDTH, 8, bit width of base, exponent and result.
- CNT_W, $clog2(WIDTH+1), bit counter width; must represent the value WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset; one clock, synchronous, active-low
- base  in  WIDTH  base operand A
- exponent  in  WIDTH  exponent operand B
- LoadA  in  1  RegA <= base
- LoadB  in  1  RegB <= exponent
- ShiftB  in  1  RegB <= RegB << 1, LSB filled with 0
- LoadCoun  in  1  counter load enable
- S_Coun  in  1  counter source: 0 = clear to 0, 1 = counter + 1
- LoadC  in  1  RegC load enable
- S_C  in  2  RegC source: 00 = 1, 01 = C*C, 10 = C*A, 11 = C (hold)
- equals  out  1  counter == WIDTH (all exponent bits consumed)
- prevRegB  out  1  RegB[WIDTH-1], the exponent bit currently under test
- result  out  WIDTH  RegC

Behaviour:
- All state updates on rising clk only; no combinational path from any control input to any register.
- Reset: while rst_n = 0 at a clock edge:
  - RegA, RegB, counter and RegC are all cleared to 0.
  - Outputs are therefore result = 0, prevRegB = 0, equals = 0.
  - Reset overrides every load/shift strobe in the same cycle.
  - Reset asserted mid-exponentiation aborts the operation; state is cleared on the next edge.
- RegA: loads base when LoadA = 1, else holds.
- RegB:
  - LoadB = 1: RegB <= exponent. LoadB has priority over ShiftB when both are asserted.
  - Else ShiftB = 1: logical shift left by 1.
  - Else hold.
- Counter:
  - LoadCoun = 1 and S_Coun = 0: counter <= 0.
  - LoadCoun = 1 and S_Coun = 1: counter <= counter + 1, saturating at WIDTH; no wrap past WIDTH.
  - LoadCoun = 0: hold.
- RegC:
  - Loads when LoadC = 1 from the source selected by S_C.
  - Products are full 2*WIDTH-bit internally; only the low WIDTH bits are stored (mod 2^WIDTH truncation).
  - S_C = 11 with LoadC = 1 is a legal no-op hold.
- equals, prevRegB, result: combinational decodes of registered state only, valid the cycle after the loading edge.
- Single-cycle operation: each strobe takes effect at the edge where it is sampled high; one strobe equals one update.
- Expected CU sequence, for reference of latency:
  - Init cycle: LoadA, LoadB, LoadCoun with S_Coun = 0, LoadC with S_C = 00.
  - Then per exponent bit:
    - Square (LoadC, S_C = 01).
    - If prevRegB = 1, multiply (LoadC, S_C = 10).
    - ShiftB together with LoadCoun, S_Coun = 1.
  - Done when equals = 1.
  - Total iteration count is WIDTH, independent of leading zeros.
- Exponent 0: all bits zero, so RegC stays 1 through every square, and result = 1.
- Base 0 with exponent ≠ 0: result = 0. Base 0 with exponent 0: result = 1.
- Simultaneous LoadA and LoadC with S_C = 10 in the same cycle: the multiply uses the old RegA value.

Test Plan:
- WIDTH = 8, base = 3, exponent = 5, full CU-style sequence -> equals rises after 8 counter increments; result = 243 (0xF3).
- base = 2, exponent = 9 -> result = 0 (512 mod 256); base = 7, exponent = 0 -> result = 1; prevRegB stays 0 throughout.
- LoadB = 1 and ShiftB = 1 in the same cycle with exponent = 0x81 -> RegB = 0x81, prevRegB = 1 (load wins).
- Twelve increments after a clear -> counter saturates at 8; equals stays 1; a clear (S_Coun = 0) drops equals the next cycle.
- Mid-run with RegC = 0x09 and the counter at 3, drive rst_n = 0 for one edge with LoadC = 1, S_C = 01 -> result = 0, equals = 0, prevRegB = 0, RegC not squared.
- LoadC = 1, S_C = 11 with RegC = 0x2A -> result remains 0x2A; LoadC = 0 with any S_C -> no change.
